// File: rtl/jtopl_reg_wr_pkg.sv
// Shared definitions for the operator register-write front end: field codes,
// register page bases, ring size and the stage offsets of the update strobes.
package jtopl_reg_wr_pkg;

    localparam int NUM_SLOTS = 18;

    typedef enum logic [1:0] {
        MULT   = 2'd0,
        KSL_TL = 2'd1,
        AR_DR  = 2'd2,
        SL_RR  = 2'd3
    } field_t;

    localparam logic [7:0] BASE_MULT   = 8'h20;
    localparam logic [7:0] BASE_KSL_TL = 8'h40;
    localparam logic [7:0] BASE_AR_DR  = 8'h60;
    localparam logic [7:0] BASE_SL_RR  = 8'h80;

    localparam logic [4:0] STG_I  = 5'd0;
    localparam logic [4:0] STG_II = 5'd1;
    localparam logic [4:0] STG_IV = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_TRAIL = 2'd2
    } state_t;

    // Slot arithmetic modulo the ring size; operands are always below the modulus.
    function automatic logic [4:0] slot_add(input logic [4:0] s, input logic [4:0] k,
                                            input logic [4:0] m);
        logic [5:0] sum;
        sum = {1'b0, s} + {1'b0, k};
        if (sum >= {1'b0, m})
            sum = sum - {1'b0, m};
        return sum[4:0];
    endfunction

endpackage

// File: rtl/jtopl_slot_dec.sv
// Combinational decode of an operator register index into field and ring slot.
// Shared with the read-back path, so it carries no state.
module jtopl_slot_dec
    import jtopl_reg_wr_pkg::*;
(
    input  logic [7:0] index,
    output logic       valid,
    output field_t     field,
    output logic [4:0] slot
);

    logic [2:0] page;
    logic [1:0] group;
    logic [2:0] sub;
    logic       page_ok;

    always_comb begin
        page    = index[7:5];
        group   = index[4:3];
        sub     = index[2:0];
        page_ok = 1'b1;
        field   = MULT;
        // Each field owns a 32-entry page, so 0x3x/0x5x/0x7x/0x9x share the field of the page below.
        case (page)
            BASE_MULT[7:5]:   field = MULT;
            BASE_KSL_TL[7:5]: field = KSL_TL;
            BASE_AR_DR[7:5]:  field = AR_DR;
            BASE_SL_RR[7:5]:  field = SL_RR;
            default:          page_ok = 1'b0;
        endcase
        valid = page_ok && (group <= 2'd2) && (sub <= 3'd5);
        slot  = 5'(group) * 5'd6 + 5'(sub);
    end

endmodule

// File: rtl/jtopl_reg_wr.sv
// Operator register-write front end: latches CPU index/data writes and holds
// them until the target slot comes round, then drives the CSR update strobes.
module jtopl_reg_wr
    import jtopl_reg_wr_pkg::*;
#(
    parameter int SLOTS = NUM_SLOTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] din,
    output logic       busy,
    output logic [4:0] slot,
    output logic [7:0] dout,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       update_op_I,
    output logic       update_op_II,
    output logic       update_op_IV
);

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [4:0] SLOT_MOD  = 5'(SLOTS);

    logic [7:0] index_reg;
    logic [7:0] dout_reg;
    logic [4:0] slot_reg;
    logic [4:0] target_reg;
    field_t     field_reg;
    state_t     state_reg, state_next;

    logic       dec_valid;
    field_t     dec_field;
    logic [4:0] dec_slot;

    logic       data_wr;
    logic       hit_i, hit_ii, hit_iv;
    logic       done_at_i;
    logic [3:0] up_vec;

    jtopl_slot_dec u_dec (
        .index (index_reg),
        .valid (dec_valid),
        .field (dec_field),
        .slot  (dec_slot)
    );

    assign busy    = (state_reg != ST_IDLE);
    assign data_wr = wr && addr && !busy && dec_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            index_reg <= 8'h00;
        else if (wr && !addr)
            index_reg <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_reg <= 5'd0;
        else if (cen)
            slot_reg <= (slot_reg == SLOT_LAST) ? 5'd0 : slot_reg + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg   <= 8'h00;
            target_reg <= 5'd0;
            field_reg  <= MULT;
        end else if (data_wr) begin
            dout_reg   <= din;
            target_reg <= dec_slot;
            field_reg  <= dec_field;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Stage II/IV are only meaningful once stage I has fired, hence TRAIL gating.
    always_comb begin
        state_next   = state_reg;
        hit_i        = (slot_reg == slot_add(target_reg, STG_I, SLOT_MOD));
        hit_ii       = (slot_reg == slot_add(target_reg, STG_II, SLOT_MOD));
        hit_iv       = (slot_reg == slot_add(target_reg, STG_IV, SLOT_MOD));
        done_at_i    = (field_reg == AR_DR) || (field_reg == SL_RR);
        update_op_I  = (state_reg == ST_PEND) && hit_i;
        update_op_II = (state_reg == ST_TRAIL) && hit_ii;
        update_op_IV = (state_reg == ST_TRAIL) && hit_iv;
        case (state_reg)
            ST_IDLE:  if (data_wr) state_next = ST_PEND;
            ST_PEND:  if (cen && hit_i) state_next = done_at_i ? ST_IDLE : ST_TRAIL;
            ST_TRAIL: if (cen && hit_iv) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_up
            assign up_vec[gi] = busy && (field_reg == 2'(gi));
        end
    endgenerate

    assign up_mult   = up_vec[MULT];
    assign up_ksl_tl = up_vec[KSL_TL];
    assign up_ar_dr  = up_vec[AR_DR];
    assign up_sl_rr  = up_vec[SL_RR];
    assign slot      = slot_reg;
    assign dout      = dout_reg;

endmodule

// File: tb/tb_jtopl_reg_wr.sv
// Directed bench for jtopl_reg_wr: each step drives a write and checks the
// strobes cycle by cycle against hand-derived slot positions.
module tb_jtopl_reg_wr;
    import jtopl_reg_wr_pkg::*;

    logic       clk = 1'b0;
    logic       rst, cen, wr, addr;
    logic [7:0] din;
    logic       busy;
    logic [4:0] slot;
    logic [7:0] dout;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr;
    logic       update_op_I, update_op_II, update_op_IV;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtopl_reg_wr #(.SLOTS(18)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .wr           (wr),
        .addr         (addr),
        .din          (din),
        .busy         (busy),
        .slot         (slot),
        .dout         (dout),
        .up_mult      (up_mult),
        .up_ksl_tl    (up_ksl_tl),
        .up_ar_dr     (up_ar_dr),
        .up_sl_rr     (up_sl_rr),
        .update_op_I  (update_op_I),
        .update_op_II (update_op_II),
        .update_op_IV (update_op_IV)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view: {busy, I, II, IV, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr}
    task automatic cyc(input string tag, input int n, input int exp_slot, input logic b,
                       input logic s1, input logic s2, input logic s4, input logic [3:0] up);
        chk($sformatf("%s_slot_n%0d", tag, n), 32'(slot), 32'(exp_slot));
        chk($sformatf("%s_sig_n%0d", tag, n),
            32'({busy, update_op_I, update_op_II, update_op_IV,
                 up_mult, up_ksl_tl, up_ar_dr, up_sl_rr}),
            32'({b, s1, s2, s4, (b ? up : 4'b0000)}));
    endtask

    task automatic wait_slot(input logic [4:0] s);
        for (int i = 0; i < 40; i++) begin
            if (slot == s) return;
            step();
        end
        chk("wait_slot_timeout", 32'(slot), 32'(s));
    endtask

    task automatic write_reg(input logic a, input logic [7:0] v);
        wr   = 1'b1;
        addr = a;
        din  = v;
        step();
        wr   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; wr = 1'b0; addr = 1'b0; din = 8'h00;
        step(); step(); step();
        cyc("reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        chk("reset_dout", 32'(dout), 32'h00);

        // Slot counter holds without cen
        rst = 1'b0; cen = 1'b0;
        step(); step(); step();
        chk("cen_hold", 32'(slot), 32'd0);
        cen = 1'b1;
        step();
        chk("cen_advance", 32'(slot), 32'd1);

        // sl_rr slot 3, captured at slot 0
        write_reg(1'b0, 8'h83);
        wait_slot(5'd0);
        write_reg(1'b1, 8'h5A);
        for (int n = 1; n <= 4; n++) begin
            cyc("slrr", n, n, n <= 3, n == 3, 1'b0, 1'b0, 4'b0001);
            step();
        end
        chk("slrr_dout", 32'(dout), 32'h5A);

        // mult slot 17: I at 17, II at 0, IV at 2
        write_reg(1'b0, 8'h35);
        wait_slot(5'd0);
        write_reg(1'b1, 8'hC3);
        for (int n = 1; n <= 21; n++) begin
            cyc("mult", n, n % 18, n <= 20, n == 17, n == 18, n == 20, 4'b1000);
            step();
        end
        chk("mult_dout", 32'(dout), 32'hC3);

        // Invalid offset and out-of-range index are ignored
        write_reg(1'b0, 8'h46);
        write_reg(1'b1, 8'h77);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("inv46_sig_n%0d", n),
                32'({busy, update_op_I, update_op_II, update_op_IV}), 32'h0);
            step();
        end
        write_reg(1'b0, 8'h9A);
        write_reg(1'b1, 8'h78);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("inv9a_sig_n%0d", n),
                32'({busy, update_op_I, update_op_II, update_op_IV}), 32'h0);
            step();
        end
        chk("invalid_dout", 32'(dout), 32'hC3);

        // ar_dr slot 0 captured at slot 10; second data write while busy is dropped
        write_reg(1'b0, 8'h60);
        wait_slot(5'd10);
        write_reg(1'b1, 8'h11);
        for (int n = 1; n <= 9; n++) begin
            cyc("ardr", n, (10 + n) % 18, n <= 8, n == 8, 1'b0, 1'b0, 4'b0010);
            if (n == 1) begin
                wr = 1'b1; addr = 1'b1; din = 8'h22;
            end
            step();
            wr = 1'b0;
        end
        chk("ardr_dout", 32'(dout), 32'h11);

        // ksl_tl slot 6 captured at slot 6: full ring before I, IV at slot 9
        write_reg(1'b0, 8'h48);
        wait_slot(5'd6);
        write_reg(1'b1, 8'h3C);
        for (int n = 1; n <= 22; n++) begin
            cyc("ksl", n, (6 + n) % 18, n <= 21, n == 18, n == 19, n == 21, 4'b0100);
            step();
        end
        chk("ksl_dout", 32'(dout), 32'h3C);

        // Reset mid-PEND drops the write
        write_reg(1'b0, 8'h83);
        wait_slot(5'd0);
        write_reg(1'b1, 8'hA5);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy_after", 32'(busy), 32'd0);
        chk("abort_dout", 32'(dout), 32'h00);
        step();
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc("abort", n, n % 18, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
